// File: rtl/bp_cce_fetch.sv
// CCE microcode fetch front end: drives the synchronous-read instruction RAM,
// predecodes a static branch hint and redirects on execute-stage mispredicts.
module bp_cce_fetch #(
    parameter int cce_pc_width_p   = 8,
    parameter int inst_width_p     = 48,
    parameter int boot_pc_p        = 0,
    parameter int perf_cnt_width_p = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    output logic                        ram_v_o,
    output logic [cce_pc_width_p-1:0]   ram_addr_o,
    input  logic [inst_width_p-1:0]     ram_data_i,

    output logic [inst_width_p-1:0]     inst_o,
    output logic                        inst_v_o,
    output logic [cce_pc_width_p-1:0]   inst_pc_o,
    output logic                        predicted_taken_o,
    output logic [cce_pc_width_p-1:0]   branch_target_o,
    input  logic                        stall_i,

    input  logic                        mispredict_i,
    input  logic [cce_pc_width_p-1:0]   pc_i,
    output logic [perf_cnt_width_p-1:0] mispredict_cnt_o
);

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_boot  = 2'd1,
        e_run   = 2'd2
    } state_e;

    localparam logic [cce_pc_width_p-1:0]   boot_pc_lp = cce_pc_width_p'(boot_pc_p);
    localparam logic [cce_pc_width_p-1:0]   pc_one_lp  = cce_pc_width_p'(1);
    localparam logic [perf_cnt_width_p-1:0] cnt_max_lp = {perf_cnt_width_p{1'b1}};
    localparam logic [perf_cnt_width_p-1:0] cnt_one_lp = perf_cnt_width_p'(1);

    state_e                        state_r;
    logic [cce_pc_width_p-1:0]     inst_pc_r;
    logic                          valid_r;
    logic [perf_cnt_width_p-1:0]   mispredict_cnt_r;

    logic                          is_branch;
    logic                          hint;
    logic [cce_pc_width_p-1:0]     target;
    logic                          predict_taken;
    logic                          fetch_en;
    logic [cce_pc_width_p-1:0]     next_pc;

    // Predecode straight off the RAM output; the RAM holds its data while not read.
    assign is_branch = ram_data_i[inst_width_p-1];
    assign hint      = ram_data_i[inst_width_p-2];
    assign target    = ram_data_i[cce_pc_width_p-1:0];

    // A mispredict squashes the instruction currently being presented.
    assign inst_v_o          = (state_r == e_run) & valid_r & ~mispredict_i;
    assign predict_taken     = inst_v_o & is_branch & hint;
    assign predicted_taken_o = predict_taken;
    assign branch_target_o   = target;
    assign inst_o            = ram_data_i;
    assign inst_pc_o         = inst_pc_r;
    assign mispredict_cnt_o  = mispredict_cnt_r;

    // Next-PC select: mispredict beats stall, stall beats the static prediction.
    always_comb begin
        fetch_en = 1'b0;
        next_pc  = inst_pc_r;
        case (state_r)
            e_boot: begin
                fetch_en = 1'b1;
                next_pc  = boot_pc_lp;
            end
            e_run: begin
                if (mispredict_i) begin
                    fetch_en = 1'b1;
                    next_pc  = pc_i;
                end else if (stall_i) begin
                    fetch_en = 1'b0;
                    next_pc  = inst_pc_r;
                end else if (predict_taken) begin
                    fetch_en = 1'b1;
                    next_pc  = target;
                end else begin
                    fetch_en = 1'b1;
                    next_pc  = inst_pc_r + pc_one_lp;
                end
            end
            default: begin
                fetch_en = 1'b0;
                next_pc  = inst_pc_r;
            end
        endcase
    end

    assign ram_v_o    = fetch_en;
    assign ram_addr_o = next_pc;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r          <= e_reset;
            inst_pc_r        <= boot_pc_lp;
            valid_r          <= 1'b0;
            mispredict_cnt_r <= '0;
        end else begin
            case (state_r)
                e_reset: state_r <= e_boot;
                e_boot:  state_r <= e_run;
                e_run:   state_r <= e_run;
                default: state_r <= e_reset;
            endcase

            // The PC register tracks the address whose data arrives next cycle.
            if (fetch_en) begin
                inst_pc_r <= next_pc;
                valid_r   <= 1'b1;
            end

            if (mispredict_i && (mispredict_cnt_r != cnt_max_lp)) begin
                mispredict_cnt_r <= mispredict_cnt_r + cnt_one_lp;
            end
        end
    end

endmodule

// File: tb/tb_bp_cce_fetch.sv
// Self-checking bench for bp_cce_fetch: scenario tasks plus randomized traffic,
// compared against a transaction-level fetch model and a behavioural RAM.
module tb_bp_cce_fetch;

    localparam logic [7:0] BOOT = 8'h00;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        ram_v_o;
    logic [7:0]  ram_addr_o;
    logic [47:0] ram_data_i;
    logic [47:0] inst_o;
    logic        inst_v_o;
    logic [7:0]  inst_pc_o;
    logic        predicted_taken_o;
    logic [7:0]  branch_target_o;
    logic        stall_i = 1'b0;
    logic        mispredict_i = 1'b0;
    logic [7:0]  pc_i = 8'h00;
    logic [15:0] mispredict_cnt_o;

    bp_cce_fetch #(
        .cce_pc_width_p  (8),
        .inst_width_p    (48),
        .boot_pc_p       (0),
        .perf_cnt_width_p(16)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n_i),
        .ram_v_o          (ram_v_o),
        .ram_addr_o       (ram_addr_o),
        .ram_data_i       (ram_data_i),
        .inst_o           (inst_o),
        .inst_v_o         (inst_v_o),
        .inst_pc_o        (inst_pc_o),
        .predicted_taken_o(predicted_taken_o),
        .branch_target_o  (branch_target_o),
        .stall_i          (stall_i),
        .mispredict_i     (mispredict_i),
        .pc_i             (pc_i),
        .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous-read RAM: data appears the cycle after a read, held otherwise.
    logic [47:0] mem [256];
    logic [47:0] ram_q = '0;
    always @(posedge clk) if (ram_v_o) ram_q <= mem[ram_addr_o];
    assign ram_data_i = ram_q;

    int errors = 0;
    int checks = 0;

    // Model: cycles since reset release, PC of the presented instruction, mispredict count.
    int          m_cyc = 0;
    logic [7:0]  m_pc  = BOOT;
    logic [15:0] m_cnt = '0;
    logic        e_ram_v, e_inst_v, e_pred;
    logic [7:0]  e_addr;
    logic [47:0] e_word;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic s, input logic m, input logic [7:0] p);
        logic taken;
        stall_i = s; mispredict_i = m; pc_i = p;
        #1;
        e_word = mem[m_pc];
        taken  = e_word[47] & e_word[46];
        e_ram_v = 1'b0; e_addr = m_pc; e_inst_v = 1'b0; e_pred = 1'b0;
        if (m_cyc == 1) begin
            e_ram_v = 1'b1; e_addr = BOOT;
        end else if (m_cyc >= 2) begin
            e_inst_v = !m;
            e_pred   = !m && taken;
            if (m) begin
                e_ram_v = 1'b1; e_addr = p;
            end else if (!s) begin
                e_ram_v = 1'b1; e_addr = taken ? e_word[7:0] : m_pc + 8'd1;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (mispredict_i && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (e_ram_v) m_pc = e_addr;
        if (m_cyc < 2) m_cyc = m_cyc + 1;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n_i = 1'b0; stall_i = 1'b0; mispredict_i = 1'b0; pc_i = 8'h00;
        repeat (2) @(negedge clk);
        m_cyc = 0; m_pc = BOOT; m_cnt = '0;
        reset_n_i = 1'b1;
    endtask

    task automatic fill_mem(input int branch_pct);
        logic [47:0] w;
        for (int i = 0; i < 256; i++) begin
            w = {16'($urandom), $urandom};
            if (int'($urandom_range(99)) >= branch_pct) w[47] = 1'b0;
            mem[i] = w;
        end
    endtask

    // Run fault-free cycles until the model presents the wanted PC; 0 if not reached.
    task automatic run_to(input logic [7:0] want, output bit ok);
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            drive(1'b0, 1'b0, 8'h00);
            if (m_cyc >= 2 && m_pc == want) begin ok = 1; break; end
            advance();
        end
        checks++; if (!ok) begin errors++; $display("FAIL run_to: pc %h not reached, got %h", want, inst_pc_o); end
    endtask

    task automatic test_reset();
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if (ram_v_o !== 1'b0) begin errors++; $display("FAIL reset_ram_v: got %b expected 0", ram_v_o); end
        checks++; if (inst_v_o !== 1'b0) begin errors++; $display("FAIL reset_inst_v: got %b expected 0", inst_v_o); end
        checks++; if (predicted_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", predicted_taken_o); end
        checks++; if (mispredict_cnt_o !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h expected 0000", mispredict_cnt_o); end
        @(negedge clk);
        $display("test_reset done, errors=%0d", errors);
    endtask

    task automatic test_linear();
        fill_mem(0);
        apply_reset();
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b0, 8'h00);
            checks++; if (ram_v_o !== (k >= 1)) begin errors++; $display("FAIL linear_ram_v[%0d]: got %b expected %b", k, ram_v_o, k >= 1); end
            checks++; if (inst_v_o !== (k >= 2)) begin errors++; $display("FAIL linear_inst_v[%0d]: got %b expected %b", k, inst_v_o, k >= 2); end
            if (k >= 1) begin
                checks++; if (ram_addr_o !== 8'(k - 1)) begin errors++; $display("FAIL linear_addr[%0d]: got %h expected %h", k, ram_addr_o, 8'(k - 1)); end
            end
            if (k >= 2) begin
                checks++; if (inst_pc_o !== 8'(k - 2)) begin errors++; $display("FAIL linear_pc[%0d]: got %h expected %h", k, inst_pc_o, 8'(k - 2)); end
                checks++; if (inst_o !== mem[k - 2]) begin errors++; $display("FAIL linear_inst[%0d]: got %h expected %h", k, inst_o, mem[k - 2]); end
            end
            advance();
        end
        $display("test_linear done, errors=%0d", errors);
    endtask

    task automatic test_branch();
        bit ok;
        fill_mem(0);
        mem[5] = {2'b11, 38'h2A_5A5A_5A5A, 8'h40};
        apply_reset();
        run_to(8'h05, ok);
        if (ok) begin
            checks++; if (predicted_taken_o !== 1'b1) begin errors++; $display("FAIL branch_pred: got %b expected 1", predicted_taken_o); end
            checks++; if (inst_pc_o !== 8'h05) begin errors++; $display("FAIL branch_pc: got %h expected 05", inst_pc_o); end
            checks++; if (branch_target_o !== 8'h40) begin errors++; $display("FAIL branch_target: got %h expected 40", branch_target_o); end
            checks++; if (ram_addr_o !== 8'h40) begin errors++; $display("FAIL branch_addr: got %h expected 40", ram_addr_o); end
            advance();
            drive(1'b0, 1'b0, 8'h00);
            checks++; if (inst_v_o !== 1'b1 || inst_pc_o !== 8'h40) begin errors++; $display("FAIL branch_next: got v=%b pc=%h expected v=1 pc=40", inst_v_o, inst_pc_o); end
            checks++; if (predicted_taken_o !== 1'b0) begin errors++; $display("FAIL branch_nottaken: got %b expected 0", predicted_taken_o); end
            advance();
        end
        $display("test_branch done, errors=%0d", errors);
    endtask

    task automatic test_mispredict();
        bit ok;
        logic [15:0] cnt_before;
        run_to(8'h41, ok);
        cnt_before = m_cnt;
        drive(1'b0, 1'b1, 8'h12);
        checks++; if (inst_v_o !== 1'b0) begin errors++; $display("FAIL mp_squash: got %b expected 0", inst_v_o); end
        checks++; if (ram_v_o !== 1'b1 || ram_addr_o !== 8'h12) begin errors++; $display("FAIL mp_addr: got v=%b addr=%h expected v=1 addr=12", ram_v_o, ram_addr_o); end
        advance();
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (inst_v_o !== 1'b1 || inst_pc_o !== 8'h12) begin errors++; $display("FAIL mp_redirect: got v=%b pc=%h expected v=1 pc=12", inst_v_o, inst_pc_o); end
        checks++; if (mispredict_cnt_o !== cnt_before + 16'd1) begin errors++; $display("FAIL mp_cnt: got %h expected %h", mispredict_cnt_o, cnt_before + 16'd1); end
        checks++; if (inst_o !== mem[8'h12]) begin errors++; $display("FAIL mp_inst: got %h expected %h", inst_o, mem[8'h12]); end
        advance();
        $display("test_mispredict done, errors=%0d", errors);
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 8'h20);
        advance();
        drive(1'b0, 1'b1, 8'h50);
        checks++; if (inst_v_o !== 1'b0 || ram_addr_o !== 8'h50) begin errors++; $display("FAIL b2b_second: got v=%b addr=%h expected v=0 addr=50", inst_v_o, ram_addr_o); end
        advance();
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (inst_v_o !== 1'b1 || inst_pc_o !== 8'h50) begin errors++; $display("FAIL b2b_latest: got v=%b pc=%h expected v=1 pc=50", inst_v_o, inst_pc_o); end
        checks++; if (mispredict_cnt_o !== m_cnt) begin errors++; $display("FAIL b2b_cnt: got %h expected %h", mispredict_cnt_o, m_cnt); end
        advance();
        $display("test_back_to_back done, errors=%0d", errors);
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 8'hFF);
        advance();
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (inst_pc_o !== 8'hFF) begin errors++; $display("FAIL wrap_pc: got %h expected ff", inst_pc_o); end
        checks++; if (ram_v_o !== 1'b1 || ram_addr_o !== 8'h00) begin errors++; $display("FAIL wrap_addr: got v=%b addr=%h expected v=1 addr=00", ram_v_o, ram_addr_o); end
        advance();
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (inst_pc_o !== 8'h00 || inst_v_o !== 1'b1) begin errors++; $display("FAIL wrap_next: got v=%b pc=%h expected v=1 pc=00", inst_v_o, inst_pc_o); end
        advance();
        $display("test_wrap done, errors=%0d", errors);
    endtask

    task automatic test_stall_mispredict();
        drive(1'b1, 1'b1, 8'h30);
        checks++; if (ram_v_o !== 1'b1 || ram_addr_o !== 8'h30) begin errors++; $display("FAIL stallmp_addr: got v=%b addr=%h expected v=1 addr=30", ram_v_o, ram_addr_o); end
        checks++; if (inst_v_o !== 1'b0) begin errors++; $display("FAIL stallmp_squash: got %b expected 0", inst_v_o); end
        advance();
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (inst_v_o !== 1'b1 || inst_pc_o !== 8'h30) begin errors++; $display("FAIL stallmp_pc: got v=%b pc=%h expected v=1 pc=30", inst_v_o, inst_pc_o); end
        advance();
        $display("test_stall_mispredict done, errors=%0d", errors);
    endtask

    task automatic test_stall();
        bit ok;
        fill_mem(0);
        apply_reset();
        run_to(8'h07, ok);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'h00);
            checks++; if (ram_v_o !== 1'b0) begin errors++; $display("FAIL stall_ram_v[%0d]: got %b expected 0", k, ram_v_o); end
            checks++; if (inst_pc_o !== 8'h07 || inst_o !== mem[7]) begin errors++; $display("FAIL stall_hold[%0d]: got pc=%h inst=%h expected pc=07 inst=%h", k, inst_pc_o, inst_o, mem[7]); end
            advance();
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (ram_v_o !== 1'b1 || ram_addr_o !== 8'h08) begin errors++; $display("FAIL stall_release: got v=%b addr=%h expected v=1 addr=08", ram_v_o, ram_addr_o); end
        advance();
        $display("test_stall done, errors=%0d", errors);
    endtask

    task automatic test_random();
        logic s, m;
        fill_mem(30);
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(99) < 25);
            m = (m_cyc >= 2) && ($urandom_range(99) < 15);
            drive(s, m, 8'($urandom));
            checks++; if (ram_v_o !== e_ram_v) begin errors++; $display("FAIL rand_ram_v[%0d]: got %b expected %b", n, ram_v_o, e_ram_v); end
            if (e_ram_v) begin
                checks++; if (ram_addr_o !== e_addr) begin errors++; $display("FAIL rand_addr[%0d]: got %h expected %h", n, ram_addr_o, e_addr); end
            end
            checks++; if (inst_v_o !== e_inst_v) begin errors++; $display("FAIL rand_inst_v[%0d]: got %b expected %b", n, inst_v_o, e_inst_v); end
            checks++; if (predicted_taken_o !== e_pred) begin errors++; $display("FAIL rand_pred[%0d]: got %b expected %b", n, predicted_taken_o, e_pred); end
            checks++; if (mispredict_cnt_o !== m_cnt) begin errors++; $display("FAIL rand_cnt[%0d]: got %h expected %h", n, mispredict_cnt_o, m_cnt); end
            if (m_cyc >= 2) begin
                checks++; if (inst_pc_o !== m_pc) begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", n, inst_pc_o, m_pc); end
                checks++; if (inst_o !== e_word) begin errors++; $display("FAIL rand_inst[%0d]: got %h expected %h", n, inst_o, e_word); end
                checks++; if (branch_target_o !== e_word[7:0]) begin errors++; $display("FAIL rand_target[%0d]: got %h expected %h", n, branch_target_o, e_word[7:0]); end
            end
            advance();
        end
        $display("test_random done, errors=%0d", errors);
    endtask

    task automatic test_reset_mid();
        fill_mem(0);
        apply_reset();
        repeat (5) begin drive(1'b0, 1'b0, 8'h00); advance(); end
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (inst_v_o !== 1'b1) begin errors++; $display("FAIL midrst_before: got %b expected 1", inst_v_o); end
        reset_n_i = 1'b0;
        #1;
        checks++; if (inst_v_o !== 1'b0 || ram_v_o !== 1'b0) begin errors++; $display("FAIL midrst_drop: got inst_v=%b ram_v=%b expected 0 0", inst_v_o, ram_v_o); end
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 8'h00);
            checks++; if (ram_v_o !== (k >= 1) || inst_v_o !== (k == 2)) begin errors++; $display("FAIL midrst_seq[%0d]: got ram_v=%b inst_v=%b expected %b %b", k, ram_v_o, inst_v_o, k >= 1, k == 2); end
            if (k == 1) begin
                checks++; if (ram_addr_o !== BOOT) begin errors++; $display("FAIL midrst_boot: got %h expected %h", ram_addr_o, BOOT); end
            end
            if (k == 2) begin
                checks++; if (inst_pc_o !== BOOT) begin errors++; $display("FAIL midrst_pc: got %h expected %h", inst_pc_o, BOOT); end
            end
            advance();
        end
        $display("test_reset_mid done, errors=%0d", errors);
    endtask

    task automatic test_saturate();
        apply_reset();
        repeat (2) begin drive(1'b0, 1'b0, 8'h00); advance(); end
        for (int i = 0; i < 65541; i++) begin
            drive(1'b0, 1'b1, 8'($urandom));
            if (i == 65534) begin
                checks++; if (mispredict_cnt_o !== 16'hFFFE) begin errors++; $display("FAIL sat_near: got %h expected fffe", mispredict_cnt_o); end
            end
            advance();
        end
        drive(1'b0, 1'b0, 8'h00);
        checks++; if (mispredict_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h expected ffff", mispredict_cnt_o); end
        advance();
        $display("test_saturate done, errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_linear();
        test_branch();
        test_mispredict();
        test_back_to_back();
        test_wrap();
        test_stall_mispredict();
        test_stall();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_cce_fetch.md
Name: bp_cce_fetch

Overview:
- Microcode fetch and branch-prediction front end of the CCE.
- Drives the synchronous-read instruction RAM and predecodes each returned instruction for a static taken/not-taken hint.
- Presents the instruction, its PC, the prediction and the branch target to the execute stage.
- Takes mispredict and corrected next PC back from the execute-stage branch evaluator and redirects fetch, squashing the wrong-path instruction.

Parameters:
- cce_pc_width_p, 8: microcode PC width; the instruction RAM holds 2^cce_pc_width_p entries.
- inst_width_p, 48: microcode instruction width; must be ≥ cce_pc_width_p+2.
- boot_pc_p, 0: first PC fetched after reset.
- perf_cnt_width_p, 16: width of the mispredict counter.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- ram_v_o  out  1  RAM read enable.
- ram_addr_o  out  cce_pc_width_p  RAM read address.
- ram_data_i  in  inst_width_p  RAM read data; valid the cycle after ram_v_o; held while ram_v_o=0.
- inst_o  out  inst_width_p  instruction to execute; equals ram_data_i.
- inst_v_o  out  1  inst_o valid.
- inst_pc_o  out  cce_pc_width_p  PC of inst_o.
- predicted_taken_o  out  1  static prediction for inst_o.
- branch_target_o  out  cce_pc_width_p  target field of inst_o.
- stall_i  in  1  execute cannot accept inst_o this cycle.
- mispredict_i  in  1  execute-stage branch resolved opposite to its prediction.
- pc_i  in  cce_pc_width_p  corrected next PC from the branch evaluator; used only with mispredict_i.
- mispredict_cnt_o  out  perf_cnt_width_p  saturating count of mispredicts.

Behaviour:
- Predecode fields of ram_data_i:
  - bit inst_width_p-1 is is_branch.
  - bit inst_width_p-2 is predict_taken hint.
  - bits [cce_pc_width_p-1:0] are the target.
  - predicted_taken_o = is_branch & hint, gated by inst_v_o.
  - branch_target_o is always the raw target field.
- State machine: e_reset → e_boot → e_run.
  - Async reset (reset_n_i=0) forces e_reset.
  - All registers clear: inst_pc_r=boot_pc_p, valid_r=0, mispredict_cnt_o=0.
  - Outputs during reset: ram_v_o=0, inst_v_o=0, predicted_taken_o=0.
- e_reset: first clock after reset deassert moves to e_boot. ram_v_o=0 in this state.
- e_boot (one cycle):
  - ram_v_o=1, ram_addr_o=boot_pc_p, inst_v_o=0.
  - Next state e_run; inst_pc_r=boot_pc_p, valid_r=1.
- e_run:
  - inst_v_o = valid_r & ~mispredict_i.
  - inst_pc_o = inst_pc_r.
  - Next-PC selection, in priority order:
    1. mispredict_i: next = pc_i.
    2. stall_i: hold; ram_v_o=0, registers unchanged, RAM output held.
    3. predicted_taken: next = branch_target_o.
    4. otherwise: next = inst_pc_r+1, wrapping modulo 2^cce_pc_width_p (max PC → 0).
  - When not holding: ram_v_o=1, ram_addr_o=next, inst_pc_r←next, valid_r←1.
- Mispredict:
  - The instruction presented in the same cycle is wrong-path and is squashed (inst_v_o=0).
  - mispredict_i overrides stall_i.
  - Penalty is exactly one bubble: the instruction at pc_i is valid the following cycle.
  - mispredict_cnt_o increments by 1 per cycle with mispredict_i=1, saturating at all-ones.
- Fetch latency: one cycle from address to valid instruction; sustained throughput is 1 instruction/cycle with no stalls.
- Back-to-back mispredicts on consecutive cycles each redirect; the latest pc_i wins.
- Reset mid-run: outputs drop immediately (asynchronously) and the sequence restarts at e_reset.

Test Plan:
- Reset release, RAM linear non-branch code at PCs 0..3, no stall:
  - ram_addr_o sequence 0,1,2,3 on consecutive cycles.
  - inst_v_o rises one cycle after e_boot.
  - inst_pc_o sequence 0,1,2,3.
- Instruction at PC 5 with is_branch=1, hint=1, target=0x40:
  - predicted_taken_o=1 with inst_pc_o=5.
  - Next ram_addr_o=0x40; next valid inst_pc_o=0x40.
- Mispredict: mispredict_i=1, pc_i=0x12 while inst_pc_o=0x41:
  - inst_v_o=0 that cycle; ram_addr_o=0x12.
  - Next cycle inst_v_o=1, inst_pc_o=0x12.
  - mispredict_cnt_o increments by 1.
- stall_i held 3 cycles at inst_pc_o=7:
  - ram_v_o=0; inst_o and inst_pc_o stable at 7.
  - On release, ram_addr_o=8.
- Wrap-around: non-branch instruction at PC 0xFF (cce_pc_width_p=8) → next fetch address 0x00.
- Corner cases:
  - stall_i and mispredict_i together with pc_i=0x30: redirect to 0x30.
  - 2^16+5 mispredicts: mispredict_cnt_o saturates at 0xFFFF.
  - reset_n_i asserted mid-stream: inst_v_o=0 immediately; restart fetch at boot_pc_p.
